// File: rtl/ne16_input_buffer_ctrl_if.sv
// Stream and buffer-port bundle for the NE16 input buffer sequencer.
// master is the sequencer's view, slave is the surrounding datapath's view.
interface ne16_input_buffer_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 128
);
  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_ready_o;
  logic                  buf_clear_o;
  logic                  buf_we_o;
  logic                  buf_we_all_o;
  logic [ADDR_WIDTH-1:0] buf_waddr_o;
  logic [DATA_WIDTH-1:0] buf_wdata_o;
  logic                  buf_re_o;
  logic [ADDR_WIDTH-1:0] buf_raddr_o;
  logic [DATA_WIDTH-1:0] buf_rdata_i;
  logic                  out_valid_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_ready_i;

  modport master (
    input  in_valid_i, in_data_i, buf_rdata_i, out_ready_i,
    output in_ready_o, buf_clear_o, buf_we_o, buf_we_all_o, buf_waddr_o,
           buf_wdata_o, buf_re_o, buf_raddr_o, out_valid_o, out_data_o
  );

  modport slave (
    output in_valid_i, in_data_i, buf_rdata_i, out_ready_i,
    input  in_ready_o, buf_clear_o, buf_we_o, buf_we_all_o, buf_waddr_o,
           buf_wdata_o, buf_re_o, buf_raddr_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/ne16_input_buffer_ctrl.sv
// NE16 input buffer sequencer: clear, fill (normal or broadcast), settle,
// then stream words out in address order with a one-entry output register.
module ne16_input_buffer_ctrl #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_WORDS  = 25
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] n_words_i,
  input  logic                  broadcast_i,
  output logic                  busy_o,
  output logic                  done_o,
  ne16_input_buffer_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_READ   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH:0]   NUM_WORDS_W = (ADDR_WIDTH+1)'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ONE_A       = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_A      = ADDR_WIDTH'(1'b0);

  state_e                state_r, state_s;
  logic [ADDR_WIDTH-1:0] n_r, n_s, n_sat_s;
  logic [ADDR_WIDTH-1:0] wcnt_r, wcnt_s;
  logic [ADDR_WIDTH-1:0] rcnt_r, rcnt_s;
  logic                  bcast_r, bcast_s;
  logic                  settle_r, settle_s;
  logic                  out_valid_r, out_valid_s;
  logic                  in_ready_s, we_s, we_all_s, clear_s, re_s, done_s;

  // Saturate the requested word count to the physical buffer depth.
  always_comb begin
    if ({1'b0, n_words_i} > NUM_WORDS_W) begin
      n_sat_s = NUM_WORDS_W[ADDR_WIDTH-1:0];
    end else begin
      n_sat_s = n_words_i;
    end
  end

  // Next-state and output decode; clear_i overrides every state.
  always_comb begin
    state_s     = state_r;
    n_s         = n_r;
    bcast_s     = bcast_r;
    wcnt_s      = wcnt_r;
    rcnt_s      = rcnt_r;
    settle_s    = settle_r;
    out_valid_s = out_valid_r;
    in_ready_s  = 1'b0;
    we_s        = 1'b0;
    we_all_s    = 1'b0;
    clear_s     = 1'b0;
    re_s        = 1'b0;
    done_s      = 1'b0;
    if (clear_i) begin
      clear_s     = 1'b1;
      state_s     = ST_IDLE;
      wcnt_s      = ZERO_A;
      rcnt_s      = ZERO_A;
      settle_s    = 1'b0;
      out_valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_s = ST_CLEAR;
            n_s     = n_sat_s;
            bcast_s = broadcast_i;
            wcnt_s  = ZERO_A;
            rcnt_s  = ZERO_A;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          clear_s = 1'b1;
          if (n_r == ZERO_A) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_LOAD: begin
          in_ready_s = 1'b1;
          if (bus.in_valid_i) begin
            we_s = 1'b1;
            if (bcast_r) begin
              we_all_s = 1'b1;
              state_s  = ST_SETTLE;
            end else begin
              wcnt_s = wcnt_r + ONE_A;
              if (wcnt_r == (n_r - ONE_A)) begin
                state_s = ST_SETTLE;
              end else begin
                state_s = ST_LOAD;
              end
            end
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_SETTLE: begin
          settle_s = ~settle_r;
          if (settle_r) begin
            state_s = ST_READ;
          end else begin
            state_s = ST_SETTLE;
          end
        end
        ST_READ: begin
          // Issue a read whenever the output register is empty or draining.
          if ((!out_valid_r || bus.out_ready_i) && (rcnt_r < n_r)) begin
            re_s        = 1'b1;
            rcnt_s      = rcnt_r + ONE_A;
            out_valid_s = 1'b1;
          end else if (bus.out_ready_i) begin
            out_valid_s = 1'b0;
          end else begin
            out_valid_s = out_valid_r;
          end
          if ((rcnt_r == n_r) && out_valid_r && bus.out_ready_i) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_READ;
          end
        end
        ST_DONE: begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and output-valid registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      n_r         <= ZERO_A;
      bcast_r     <= 1'b0;
      wcnt_r      <= ZERO_A;
      rcnt_r      <= ZERO_A;
      settle_r    <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      n_r         <= n_s;
      bcast_r     <= bcast_s;
      wcnt_r      <= wcnt_s;
      rcnt_r      <= rcnt_s;
      settle_r    <= settle_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign bus.in_ready_o   = in_ready_s;
  assign bus.buf_clear_o  = clear_s;
  assign bus.buf_we_o     = we_s;
  assign bus.buf_we_all_o = we_all_s;
  assign bus.buf_waddr_o  = wcnt_r;
  assign bus.buf_wdata_o  = bus.in_data_i;
  assign bus.buf_re_o     = re_s;
  assign bus.buf_raddr_o  = rcnt_r;
  assign bus.out_valid_o  = out_valid_r;
  assign bus.out_data_o   = bus.buf_rdata_i;
  assign busy_o           = (state_r != ST_IDLE);
  assign done_o           = done_s;

endmodule

// File: doc/ne16_input_buffer_ctrl.md
Name: ne16_input_buffer_ctrl

Overview:
Sequencer for the NE16 latch-based input buffer: clears it, fills it from an incoming valid/ready stream, waits for the write pipeline to settle, then streams words back out in address order.
Drives the buffer's write/read ports directly.
Sits between the input streamer (source) and the buffer's read consumer (sink).
Supports a broadcast mode in which a single beat is written to every word through the write-all path.

Parameters:
ADDR_WIDTH, 5, width of buffer address and word-count fields
DATA_WIDTH, 128, width of one buffer word
NUM_WORDS, 25, number of buffer words (must be <= 2**ADDR_WIDTH)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear, aborts any operation
start_i  in  1  start pulse; sampled only in IDLE
n_words_i  in  ADDR_WIDTH  words to load/read; sampled with start_i
broadcast_i  in  1  broadcast mode; sampled with start_i
in_valid_i  in  1  input stream valid
in_data_i  in  DATA_WIDTH  input stream data
in_ready_o  out  1  input stream ready
buf_clear_o  out  1  buffer clear
buf_we_o  out  1  buffer write enable
buf_we_all_o  out  1  buffer write-all enable
buf_waddr_o  out  ADDR_WIDTH  buffer write address
buf_wdata_o  out  DATA_WIDTH  buffer write data (= in_data_i)
buf_re_o  out  1  buffer read enable
buf_raddr_o  out  ADDR_WIDTH  buffer read address
buf_rdata_i  in  DATA_WIDTH  buffer registered read data
out_valid_o  out  1  output stream valid
out_data_o  out  DATA_WIDTH  output stream data (= buf_rdata_i)
out_ready_i  in  1  output stream ready
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset: FSM=IDLE, all counters 0, out_valid_o=0. Every output is 0 except the data pass-throughs (buf_wdata_o, out_data_o).
- Word count: N = min(n_words_i, NUM_WORDS), latched at start. N==0 skips LOAD and READ and goes CLEAR -> DONE.
- IDLE: start_i=1 -> CLEAR. start_i is ignored in every other state.
- CLEAR (1 cycle): buf_clear_o=1 -> LOAD.
- LOAD, normal mode:
  - in_ready_o=1.
  - A beat is accepted when in_valid_i && in_ready_o; that cycle buf_we_o=1 and buf_waddr_o=wcnt, then wcnt++.
  - When the N-th beat is accepted -> SETTLE, with in_ready_o=0 from the next cycle.
- LOAD, broadcast mode:
  - First accepted beat drives buf_we_o=1 and buf_we_all_o=1, then -> SETTLE. Exactly one beat is consumed.
  - READ still returns N words.
- SETTLE (exactly 2 cycles): covers the buffer's write-data register plus latch transparency. No re is issued. -> READ.
- READ:
  - buf_re_o=1 with buf_raddr_o=rcnt when (!out_valid_o || out_ready_i) && rcnt<N; then rcnt++.
  - out_valid_o is set the cycle after a re. It clears on handshake unless a new re fired in the same cycle.
  - Back-to-back throughput is 1 word/cycle. Words must never be dropped or duplicated under arbitrary out_ready_i.
  - When rcnt==N and the last word has handshaked -> DONE.
- DONE (1 cycle): done_o=1 -> IDLE.
- Counters never exceed N-1 as addresses; no wrap-around.
- clear_i has priority in any state:
  - buf_clear_o=1 that cycle.
  - Next state IDLE; counters and out_valid_o reset.
  - No done_o is produced.
  - in_ready_o, buf_we_o, buf_we_all_o and buf_re_o are forced to 0 in that cycle.
- start_i and clear_i together in IDLE: clear_i wins; remain IDLE.

Test Plan:
- Reset, then start with N=4: 4 beats D0..D3 with in_valid_i always high -> buf_waddr_o 0,1,2,3 on consecutive cycles. After 2 SETTLE cycles, out_data_o = D0..D3 in order, then done_o pulses once. busy_o is high from the cycle after start until DONE.
- N=3 with in_valid_i toggling 1/0 and out_ready_i random (seeded) -> exactly 3 writes and 3 output handshakes, in order, with no duplicate or missing word.
- Broadcast, N=5, one beat 0xA5..A5 -> single cycle with buf_we_o=buf_we_all_o=1, in_ready_o low afterwards, 5 output words all equal to 0xA5..A5.
- n_words_i=0 -> sequence CLEAR then DONE only, no we/re. n_words_i=31 -> N saturates to 25, last waddr=24.
- clear_i asserted during the 2nd READ word -> buf_clear_o=1, next cycle IDLE with out_valid_o=0 and no done_o. A following start behaves normally.
- rst_ni asserted mid-LOAD -> all outputs return to reset values immediately (asynchronously).
